// File: rtl/if_stage_pkg.sv
// Shared definitions for the 16-bit core fetch stage: word width, reset/NOP
// encodings, fetch FSM states and a saturating-increment helper.
package if_stage_pkg;

   localparam int unsigned WORD_W = 16;

   typedef logic [WORD_W-1:0] word_t;

   localparam word_t       RESET_PC_DEF  = 16'h0000;
   localparam word_t       NOP_INSTR_DEF = 16'h0000;
   localparam int unsigned PC_STEP_DEF   = 1;

   typedef enum logic {
      ST_BOOT = 1'b0,
      ST_RUN  = 1'b1
   } if_state_e;

   function automatic word_t sat_inc(input word_t v);
      return (v == '1) ? v : v + word_t'(1);
   endfunction

endpackage : if_stage_pkg

// File: rtl/if_id_reg.sv
// Generic pipeline register carrying instr, pc_plus1 and valid.
// Priority: flush (insert bubble) > hold (keep contents) > load.
module if_id_reg #(
   parameter int unsigned     W   = 16,
   parameter logic [W-1:0]    NOP = '0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush_i,
   input  logic          hold_i,
   input  logic          load_i,
   input  logic [W-1:0]  instr_i,
   input  logic [W-1:0]  pc_plus1_i,
   output logic [W-1:0]  instr_o,
   output logic [W-1:0]  pc_plus1_o,
   output logic          valid_o
);

   logic [W-1:0] instr_q, instr_d;
   logic [W-1:0] pc_plus1_q, pc_plus1_d;
   logic         valid_q, valid_d;

   // NOTE: every next-state value gets a default before the branches so that
   // no path leaves it unassigned, which would infer a latch.
   always_comb begin
      instr_d    = instr_q;
      pc_plus1_d = pc_plus1_q;
      valid_d    = valid_q;
      if (flush_i) begin
         instr_d    = NOP;
         pc_plus1_d = '0;
         valid_d    = 1'b0;
      end else if (!hold_i && load_i) begin
         instr_d    = instr_i;
         pc_plus1_d = pc_plus1_i;
         valid_d    = 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops sample
   // their inputs from the same pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_q    <= NOP;
         pc_plus1_q <= '0;
         valid_q    <= 1'b0;
      end else begin
         instr_q    <= instr_d;
         pc_plus1_q <= pc_plus1_d;
         valid_q    <= valid_d;
      end
   end

   assign instr_o    = instr_q;
   assign pc_plus1_o = pc_plus1_q;
   assign valid_o    = valid_q;

endmodule : if_id_reg

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, BOOT/RUN sequencer, bubble counter
// and the IF/ID pipeline register feeding decode.
module if_stage
   import if_stage_pkg::*;
#(
   parameter word_t       RESET_PC  = RESET_PC_DEF,
   parameter word_t       NOP_INSTR = NOP_INSTR_DEF,
   parameter int unsigned PC_STEP   = PC_STEP_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        IF_ID_sync_nop,
   input  logic        stall,
   input  logic        redirect,
   input  word_t       redirect_target,
   output word_t       imem_addr,
   input  word_t       imem_data,
   output word_t       IF_ID_instr,
   output word_t       IF_ID_pc_plus1,
   output logic        IF_ID_valid,
   output word_t       bubble_count
);

   localparam word_t STEP = word_t'(PC_STEP);

   if_state_e state_q, state_d;
   word_t     pc_q, pc_d;
   word_t     bubble_q, bubble_d;
   word_t     pc_seq;
   logic      reg_flush, reg_hold, reg_load;

   // Modulo-2^16 add: 16'hFFFF + 1 wraps to 0 for both PC and link value.
   assign pc_seq = pc_q + STEP;

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      bubble_d  = bubble_q;
      reg_flush = 1'b0;
      reg_hold  = 1'b0;
      reg_load  = 1'b0;
      unique case (state_q)
         ST_BOOT: begin
            reg_flush = 1'b1;
            state_d   = ST_RUN;
         end
         ST_RUN: begin
            if (IF_ID_sync_nop) begin
               reg_flush = 1'b1;
               bubble_d  = sat_inc(bubble_q);
               pc_d      = redirect ? redirect_target : pc_seq;
            end else if (stall) begin
               // Redirect still wins over the stall for the PC only.
               reg_hold = 1'b1;
               pc_d     = redirect ? redirect_target : pc_q;
            end else begin
               reg_load = 1'b1;
               pc_d     = redirect ? redirect_target : pc_seq;
            end
         end
         default: state_d = ST_BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_BOOT;
         pc_q     <= RESET_PC;
         bubble_q <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         bubble_q <= bubble_d;
      end
   end

   if_id_reg #(
      .W   (WORD_W),
      .NOP (NOP_INSTR)
   ) u_if_id_reg (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush_i    (reg_flush),
      .hold_i     (reg_hold),
      .load_i     (reg_load),
      .instr_i    (imem_data),
      .pc_plus1_i (pc_seq),
      .instr_o    (IF_ID_instr),
      .pc_plus1_o (IF_ID_pc_plus1),
      .valid_o    (IF_ID_valid)
   );

   assign imem_addr    = pc_q;
   assign bubble_count = bubble_q;

endmodule : if_stage

// File: tb/tb_if_stage.sv
// Directed bench for if_stage; instruction memory returns 16'h1000 + address.
module tb_if_stage;

   logic        clk;
   logic        rst_n;
   logic        IF_ID_sync_nop;
   logic        stall;
   logic        redirect;
   logic [15:0] redirect_target;
   logic [15:0] imem_addr;
   logic [15:0] imem_data;
   logic [15:0] IF_ID_instr;
   logic [15:0] IF_ID_pc_plus1;
   logic        IF_ID_valid;
   logic [15:0] bubble_count;

   int n_checks = 0;
   int n_fail   = 0;

   if_stage dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .IF_ID_sync_nop  (IF_ID_sync_nop),
      .stall           (stall),
      .redirect        (redirect),
      .redirect_target (redirect_target),
      .imem_addr       (imem_addr),
      .imem_data       (imem_data),
      .IF_ID_instr     (IF_ID_instr),
      .IF_ID_pc_plus1  (IF_ID_pc_plus1),
      .IF_ID_valid     (IF_ID_valid),
      .bubble_count    (bubble_count)
   );

   assign imem_data = 16'h1000 + imem_addr;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One rising edge, then sample/drive on the falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_ifid(input string tag, input logic [15:0] instr,
                             input logic [15:0] pcp1, input logic valid);
      check({tag, ".instr"}, {16'h0, IF_ID_instr}, {16'h0, instr});
      check({tag, ".pcp1"},  {16'h0, IF_ID_pc_plus1}, {16'h0, pcp1});
      check({tag, ".valid"}, {31'h0, IF_ID_valid}, {31'h0, valid});
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, ".addr"},   {16'h0, imem_addr}, 32'h0);
      check_ifid(tag, 16'h0000, 16'h0000, 1'b0);
      check({tag, ".bubble"}, {16'h0, bubble_count}, 32'h0);
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n           = 1'b0;
      IF_ID_sync_nop  = 1'b0;
      stall           = 1'b0;
      redirect        = 1'b0;
      redirect_target = 16'h0000;
      @(negedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;

      // BOOT cycle: bubble, PC held at reset value.
      tick();
      check_ifid("boot", 16'h0000, 16'h0000, 1'b0);
      check("boot.addr", {16'h0, imem_addr}, 32'h0);

      // Sequential fetch 0..4.
      for (int a = 0; a < 5; a++) begin
         tick();
         check_ifid($sformatf("seq%0d", a), 16'h1000 + 16'(a), 16'(a + 1), 1'b1);
      end
      check("seq.addr", {16'h0, imem_addr}, 32'h5);

      // Stall three cycles at PC=5.
      stall = 1'b1;
      for (int s = 0; s < 3; s++) begin
         tick();
         check($sformatf("stall%0d.addr", s), {16'h0, imem_addr}, 32'h5);
         check($sformatf("stall%0d.instr", s), {16'h0, IF_ID_instr}, 32'h1004);
      end
      stall = 1'b0;
      tick();
      check_ifid("unstall", 16'h1005, 16'h0006, 1'b1);

      // Redirect to 0x40 together with a flush.
      redirect = 1'b1; redirect_target = 16'h0040; IF_ID_sync_nop = 1'b1;
      tick();
      redirect = 1'b0; IF_ID_sync_nop = 1'b0;
      check("redir.valid",  {31'h0, IF_ID_valid}, 32'h0);
      check("redir.addr",   {16'h0, imem_addr}, 32'h40);
      check("redir.bubble", {16'h0, bubble_count}, 32'h1);
      tick();
      check_ifid("redir.tgt", 16'h1040, 16'h0041, 1'b1);

      // Plain redirect (no flush) to 8: current fetch still loads.
      redirect = 1'b1; redirect_target = 16'h0008;
      tick();
      redirect = 1'b0;
      check_ifid("redir8", 16'h1041, 16'h0042, 1'b1);
      check("redir8.addr", {16'h0, imem_addr}, 32'h8);

      // Flush overrides stall; PC still advances.
      IF_ID_sync_nop = 1'b1; stall = 1'b1;
      tick();
      IF_ID_sync_nop = 1'b0; stall = 1'b0;
      check("nopstall.valid",  {31'h0, IF_ID_valid}, 32'h0);
      check("nopstall.addr",   {16'h0, imem_addr}, 32'h9);
      check("nopstall.bubble", {16'h0, bubble_count}, 32'h2);
      tick();
      check_ifid("after_nop", 16'h1009, 16'h000A, 1'b1);

      // Wrap at 16'hFFFF.
      redirect = 1'b1; redirect_target = 16'hFFFF;
      tick();
      redirect = 1'b0;
      check("wrap.addr", {16'h0, imem_addr}, 32'hFFFF);
      tick();
      check_ifid("wrap", 16'h0FFF, 16'h0000, 1'b1);
      check("wrap.addr0", {16'h0, imem_addr}, 32'h0);

      // Redirect during stall moves PC, IF/ID holds, no bubble counted.
      stall = 1'b1; redirect = 1'b1; redirect_target = 16'h0020;
      tick();
      stall = 1'b0; redirect = 1'b0;
      check_ifid("stallredir", 16'h0FFF, 16'h0000, 1'b1);
      check("stallredir.addr",   {16'h0, imem_addr}, 32'h20);
      check("stallredir.bubble", {16'h0, bubble_count}, 32'h2);

      // Asynchronous reset in the middle of a flush/redirect cycle.
      IF_ID_sync_nop = 1'b1; redirect = 1'b1; redirect_target = 16'h0077;
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      IF_ID_sync_nop = 1'b0; redirect = 1'b0;
      tick();
      check_reset_outputs("rst_held");
      rst_n = 1'b1;
      tick();
      check_ifid("reboot", 16'h0000, 16'h0000, 1'b0);
      check("reboot.addr", {16'h0, imem_addr}, 32'h0);
      tick();
      check_ifid("rerun", 16'h1000, 16'h0001, 1'b1);
      check("rerun.addr", {16'h0, imem_addr}, 32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_if_stage
